// File: rtl/puf_eval_sequencer.sv
// puf_eval_sequencer: drives a challenge into an XOR-APUF, fires it NUM_EVAL times, majority-votes the responses.
// Optional macro PUF_STABILITY_EN adds the 'unstable' mixed-response flag.
module puf_eval_sequencer #(
  parameter int  N           = 64,
  parameter int  NUM_EVAL    = 15,
  parameter int  SETTLE_CYC  = 4,
  parameter int  RELAX_CYC   = 4,
  parameter int  TIMEOUT_CYC = 255,
  localparam int CW          = $clog2(NUM_EVAL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  chal_in,
  input  logic          puf_resp_ready,
  input  logic          puf_resp,
  output logic [N-1:0]  puf_chal,
  output logic          puf_trig,
  output logic          busy,
  output logic          resp_valid,
  output logic          resp_bit,
  output logic [CW-1:0] ones_cnt,
  output logic          timeout_err
`ifdef PUF_STABILITY_EN
  ,
  output logic          unstable
`endif
);

  localparam int PMAX = (SETTLE_CYC > RELAX_CYC) ? SETTLE_CYC : RELAX_CYC;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int WR   = $clog2(TIMEOUT_CYC + 1);
  localparam int WW   = (WR > 8) ? WR : 8;

  localparam logic [CW-1:0] NE_C   = CW'(NUM_EVAL);
  localparam logic [CW-1:0] HALF   = CW'(NUM_EVAL / 2);
  localparam logic [PW-1:0] ST_END = PW'(SETTLE_CYC - 1);
  localparam logic [PW-1:0] RX_END = PW'(RELAX_CYC - 1);
  localparam logic [WW-1:0] TO_END = WW'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_FIRE,
    S_WAIT,
    S_RELAX,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  chal_q, chal_d;
  logic          trig_q, trig_d;
  logic [CW-1:0] ones_q, ones_d;
  logic [CW-1:0] eval_q, eval_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [PW-1:0] ph_q, ph_d;
  logic          to_q, to_d;
  logic          bit_q, bit_d;
`ifdef PUF_STABILITY_EN
  logic          unst_q, unst_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      chal_q  <= '0;
      trig_q  <= 1'b0;
      ones_q  <= '0;
      eval_q  <= '0;
      wait_q  <= '0;
      ph_q    <= '0;
      to_q    <= 1'b0;
      bit_q   <= 1'b0;
`ifdef PUF_STABILITY_EN
      unst_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      chal_q  <= chal_d;
      trig_q  <= trig_d;
      ones_q  <= ones_d;
      eval_q  <= eval_d;
      wait_q  <= wait_d;
      ph_q    <= ph_d;
      to_q    <= to_d;
      bit_q   <= bit_d;
`ifdef PUF_STABILITY_EN
      unst_q  <= unst_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    chal_d  = chal_q;
    trig_d  = trig_q;
    ones_d  = ones_q;
    eval_d  = eval_q;
    wait_d  = wait_q;
    ph_d    = ph_q;
    to_d    = to_q;
    bit_d   = bit_q;
`ifdef PUF_STABILITY_EN
    unst_d  = unst_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          chal_d  = chal_in;
          ones_d  = '0;
          eval_d  = '0;
          to_d    = 1'b0;
          bit_d   = 1'b0;
          ph_d    = '0;
`ifdef PUF_STABILITY_EN
          unst_d  = 1'b0;
`endif
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (ph_q == ST_END) begin
          ph_d    = '0;
          state_d = S_FIRE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_FIRE: begin
        trig_d  = 1'b1;
        wait_d  = WW'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // a response arriving on the timeout cycle still counts
        if (puf_resp_ready) begin
          if (ones_q != NE_C) begin
            ones_d = ones_q + CW'(puf_resp);
          end
          eval_d  = eval_q + 1'b1;
          trig_d  = 1'b0;
          ph_d    = '0;
          state_d = S_RELAX;
        end else if (wait_q == TO_END) begin
          trig_d  = 1'b0;
          to_d    = 1'b1;
          bit_d   = 1'b0;
`ifdef PUF_STABILITY_EN
          unst_d  = 1'b0;
`endif
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RELAX: begin
        if (ph_q == RX_END) begin
          ph_d = '0;
          if (eval_q < NE_C) begin
            state_d = S_FIRE;
          end else begin
            bit_d   = (ones_q > HALF);
`ifdef PUF_STABILITY_EN
            unst_d  = (ones_q != '0) && (ones_q != NE_C);
`endif
            state_d = S_DONE;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign puf_chal    = chal_q;
  assign puf_trig    = trig_q;
  assign busy        = (state_q != S_IDLE);
  assign resp_valid  = (state_q == S_DONE);
  assign resp_bit    = bit_q;
  assign ones_cnt    = ones_q;
  assign timeout_err = to_q;
`ifdef PUF_STABILITY_EN
  assign unstable    = unst_q;
`endif

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// tb_puf_eval_sequencer: randomized PUF responder plus a procedural reference model.
// Directed runs pin latency and vote results; random runs lean on the model.
module tb_puf_eval_sequencer;

  localparam int N  = 64;
  localparam int NE = 15;
  localparam int ST = 4;
  localparam int RX = 4;
  localparam int TO = 8;
  localparam int CW = $clog2(NE + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  chal_in;
  logic          puf_resp_ready;
  logic          puf_resp;
  logic [N-1:0]  puf_chal;
  logic          puf_trig;
  logic          busy;
  logic          resp_valid;
  logic          resp_bit;
  logic [CW-1:0] ones_cnt;
  logic          timeout_err;
`ifdef PUF_STABILITY_EN
  logic          unstable;
`endif

  puf_eval_sequencer #(
    .N(N), .NUM_EVAL(NE), .SETTLE_CYC(ST),
    .RELAX_CYC(RX), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .chal_in(chal_in),
    .puf_resp_ready(puf_resp_ready),
    .puf_resp(puf_resp),
    .puf_chal(puf_chal),
    .puf_trig(puf_trig),
    .busy(busy),
    .resp_valid(resp_valid),
    .resp_bit(resp_bit),
    .ones_cnt(ones_cnt),
    .timeout_err(timeout_err)
`ifdef PUF_STABILITY_EN
    ,
    .unstable(unstable)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus driver ----------------
  int          req_id = 0;
  logic [N-1:0] req_chal = '0;
  logic [14:0] pat = '0;
  int          fix_delay = 0;
  bit          rmode = 1'b0;
  bit          abuse = 1'b0;
  bit          want_rst = 1'b1;
  int          t_start = 0;

  function automatic int pick();
    if (!rmode) return fix_delay;
    if ($urandom_range(0, 19) == 0) return 9;
    return int'($urandom_range(1, 8));
  endfunction

  initial begin : drv
    int seen;
    int wcnt;
    int eidx;
    int cd;
    seen = 0; wcnt = 0; eidx = 0; cd = 0;
    rst = 1'b1; start = 1'b0; chal_in = '0;
    puf_resp_ready = 1'b0; puf_resp = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rst = want_rst;
      wcnt = puf_trig ? wcnt + 1 : 0;
      start = 1'b0;
      puf_resp_ready = 1'b0;
      puf_resp = 1'b0;
      if (req_id != seen) begin
        seen = req_id;
        start = 1'b1;
        chal_in = req_chal;
        t_start = cyc;
        eidx = 0;
        cd = pick();
      end else if (abuse && busy && !puf_trig && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        chal_in = {$urandom, $urandom};
      end
      if (puf_trig) begin
        if (wcnt == cd) begin
          puf_resp_ready = 1'b1;
          puf_resp = (eidx < 15) ? pat[eidx] : 1'b0;
          eidx++;
          cd = pick();
        end
      end else if (abuse && $urandom_range(0, 2) == 0) begin
        puf_resp_ready = 1'b1;
        puf_resp = 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  bit          e_busy, e_trig, e_valid, e_bit, e_to, e_unst;
  logic [N-1:0] e_chal;
  int          e_ones;
  bit          s_rdy, s_resp;

  task automatic clr();
    e_busy = 0; e_trig = 0; e_valid = 0; e_bit = 0;
    e_to = 0; e_unst = 0; e_chal = '0; e_ones = 0;
  endtask

  task automatic step(output bit ab);
    @(posedge clk);
    s_rdy = puf_resp_ready;
    s_resp = puf_resp;
    ab = rst;
    if (rst) clr();
  endtask

  task automatic finish_done(output bit ab);
    e_valid = 1;
    e_bit = !e_to && (e_ones > NE / 2);
    e_unst = !e_to && (e_ones > 0) && (e_ones < NE);
    step(ab);
    if (ab) return;
    e_valid = 0;
    e_busy = 0;
  endtask

  task automatic run();
    bit ab;
    int w;
    int ev;
    e_chal = chal_in; e_ones = 0; e_to = 0; e_bit = 0;
    e_unst = 0; e_busy = 1; e_trig = 0; e_valid = 0;
    repeat (ST) begin
      step(ab);
      if (ab) return;
    end
    ev = 0;
    forever begin
      step(ab);
      if (ab) return;
      e_trig = 1;
      w = 0;
      forever begin
        w++;
        step(ab);
        if (ab) return;
        if (s_rdy) begin
          if (e_ones < NE) e_ones += int'(s_resp);
          ev++;
          e_trig = 0;
          break;
        end
        if (w == TO) begin
          e_trig = 0;
          e_to = 1;
          finish_done(ab);
          return;
        end
      end
      repeat (RX) begin
        step(ab);
        if (ab) return;
      end
      if (ev >= NE) begin
        finish_done(ab);
        return;
      end
    end
  endtask

  initial begin : model
    clr();
    forever begin
      @(posedge clk);
      if (rst) clr();
      else if (start) run();
    end
  end

  // ---------------- checker / sequence ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (cyc > 0) begin
      chk("busy", 64'(busy), 64'(e_busy));
      chk("puf_trig", 64'(puf_trig), 64'(e_trig));
      chk("resp_valid", 64'(resp_valid), 64'(e_valid));
      chk("resp_bit", 64'(resp_bit), 64'(e_bit));
      chk("timeout_err", 64'(timeout_err), 64'(e_to));
      chk("ones_cnt", 64'(ones_cnt), 64'(e_ones));
      chk("puf_chal", puf_chal, e_chal);
`ifdef PUF_STABILITY_EN
      chk("unstable", 64'(unstable), 64'(e_unst));
`endif
    end
  endtask

  task automatic launch(logic [N-1:0] c, logic [14:0] p, int d, bit rm, bit ab);
    req_chal = c;
    pat = p;
    fix_delay = d;
    rmode = rm;
    abuse = ab;
    req_id++;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (resp_valid === 1'b1) begin
        lat = cyc - t_start + 1;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL valid_wait: got no resp_valid want a pulse");
  endtask

  initial begin : main
    int lat;
    bit seen_trig;
    logic [N-1:0] c0;
    logic [N-1:0] b2b;
    b2b = 64'hA5A5_5A5A_0F0F_F0F0;

    repeat (3) tick();
    want_rst = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_trig", 64'(puf_trig), 0);
    chk("rst_ones", 64'(ones_cnt), 0);
    chk("rst_chal", puf_chal, 0);

    // nominal 10/15, ready two cycles after trigger
    c0 = {$urandom, $urandom};
    launch(c0, 15'b110101101101011, 2, 0, 0);
    wait_valid(lat);
    chk("nom_lat", 64'(lat), 111);
    chk("nom_ones", 64'(ones_cnt), 10);
    chk("nom_bit", 64'(resp_bit), 1);
    chk("nom_to", 64'(timeout_err), 0);
    chk("nom_chal", puf_chal, c0);

    // back-to-back minority run
    launch(b2b, 15'b010101010101010, 2, 0, 0);
    tick();
    chk("b2b_pulse_1cyc", 64'(resp_valid), 0);
    chk("b2b_hold_ones", 64'(ones_cnt), 10);
    wait_valid(lat);
    chk("min_lat", 64'(lat), 111);
    chk("min_chal", puf_chal, b2b);
    chk("min_ones", 64'(ones_cnt), 7);
    chk("min_bit", 64'(resp_bit), 0);
`ifdef PUF_STABILITY_EN
    chk("min_unstable", 64'(unstable), 1);
`endif

    // unanimous run
    launch({$urandom, $urandom}, 15'h7FFF, 1, 0, 0);
    wait_valid(lat);
    chk("all_lat", 64'(lat), 96);
    chk("all_ones", 64'(ones_cnt), 15);
    chk("all_bit", 64'(resp_bit), 1);
`ifdef PUF_STABILITY_EN
    chk("all_unstable", 64'(unstable), 0);
`endif
    repeat (2) tick();

    // timeout: ready never comes
    launch({$urandom, $urandom}, 15'h7FFF, 0, 0, 0);
    wait_valid(lat);
    chk("to_lat", 64'(lat), 15);
    chk("to_err", 64'(timeout_err), 1);
    chk("to_bit", 64'(resp_bit), 0);
    chk("to_trig", 64'(puf_trig), 0);
    repeat (2) tick();

    // ready on the timeout cycle
    launch({$urandom, $urandom}, 15'b110101101101011, 8, 0, 0);
    wait_valid(lat);
    chk("rt_lat", 64'(lat), 201);
    chk("rt_err", 64'(timeout_err), 0);
    chk("rt_ones", 64'(ones_cnt), 10);
    chk("rt_bit", 64'(resp_bit), 1);
    repeat (2) tick();

    // stray start / ready outside WAIT
    c0 = {$urandom, $urandom};
    launch(c0, 15'h0000, 3, 0, 1);
    wait_valid(lat);
    abuse = 1'b0;
    chk("ab_lat", 64'(lat), 126);
    chk("ab_chal", puf_chal, c0);
    chk("ab_ones", 64'(ones_cnt), 0);
    chk("ab_bit", 64'(resp_bit), 0);
    repeat (2) tick();

    // reset held three cycles mid-WAIT
    launch({$urandom, $urandom}, 15'h7FFF, 0, 0, 0);
    seen_trig = 1'b0;
    for (int i = 0; i < 30 && !seen_trig; i++) begin
      tick();
      if (puf_trig === 1'b1) seen_trig = 1'b1;
    end
    if (!seen_trig) begin
      total++;
      bad++;
      $display("FAIL trig_wait: got no puf_trig want high");
    end
    want_rst = 1'b1;
    repeat (3) tick();
    want_rst = 1'b0;
    tick();
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_trig", 64'(puf_trig), 0);
    chk("mid_rst_chal", puf_chal, 0);
    chk("mid_rst_valid", 64'(resp_valid), 0);
    chk("mid_rst_ones", 64'(ones_cnt), 0);
    repeat (2) tick();

    // randomized runs
    for (int r = 0; r < 12; r++) begin
      launch({$urandom, $urandom}, 15'($urandom), 0, 1, bit'($urandom_range(0, 1)));
      wait_valid(lat);
      abuse = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/puf_eval_sequencer.md
Name: puf_eval_sequencer

Overview:
- Sits between the PicoBlaze PUF controller (upstream) and the XOR-APUF core (downstream).
- On a start pulse, latches the 64-bit challenge and drives it onto the PUF.
- Fires the PUF trigger NUM_EVAL times and collects one response bit per firing.
- Reports the majority-voted response bit and the ones-count back to the controller, with a done pulse and a timeout error flag.

Parameters:
- N, 64, challenge width.
- NUM_EVAL, 15, evaluations per challenge; must be odd, 1..255.
- SETTLE_CYC, 4, cycles the challenge is held stable before the first trigger; must be >=1.
- RELAX_CYC, 4, cycles trigger stays low between evaluations; must be >=1.
- TIMEOUT_CYC, 255, maximum WAIT cycles before abort; must be >=1.
- CW, derived as $clog2(NUM_EVAL+1), width of the count fields.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request from controller.
- chal_in  in  N  challenge from controller's challenge register.
- puf_resp_ready  in  1  PUF arbiter-done strobe.
- puf_resp  in  1  PUF XOR response bit.
- puf_chal  out  N  challenge driven to PUF.
- puf_trig  out  1  PUF trigger (tigSignal).
- busy  out  1  high in every state except IDLE.
- resp_valid  out  1  one-cycle done pulse.
- resp_bit  out  1  majority result.
- ones_cnt  out  CW  number of 1 responses collected.
- timeout_err  out  1  last run aborted by timeout.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; all outputs 0; internal counters 0. Reset mid-run aborts immediately, with no resp_valid pulse.
- IDLE:
  - start=1 latches chal_in into puf_chal, clears ones_cnt, eval counter and timeout_err, then goes to SETTLE.
  - start in any other state is ignored.
- SETTLE: counts SETTLE_CYC cycles, then goes to FIRE. puf_chal is stable from the cycle after start until the next start.
- FIRE: sets puf_trig=1, goes to WAIT. Trigger is registered and rises on the edge leaving FIRE.
- WAIT:
  - puf_trig stays 1; the wait counter increments each cycle.
  - If puf_resp_ready=1: sample puf_resp, add it to ones_cnt, increment eval counter, clear puf_trig, go to RELAX.
  - Else if the wait counter reaches TIMEOUT_CYC: clear puf_trig, set timeout_err=1, go to DONE.
  - Ready and timeout in the same cycle: ready wins.
- RELAX:
  - Counts RELAX_CYC cycles with puf_trig=0.
  - Then goes to FIRE if eval counter < NUM_EVAL, else DONE.
  - Any puf_resp_ready seen outside WAIT is ignored.
- DONE:
  - resp_valid=1 for exactly one cycle.
  - resp_bit = (ones_cnt > NUM_EVAL/2) and not timeout_err.
  - Returns to IDLE next cycle.
  - resp_bit, ones_cnt and timeout_err hold until the next accepted start.
- Arithmetic:
  - ones_cnt saturates at NUM_EVAL (unreachable in legal operation).
  - All counters are unsigned; eval counter is CW bits; wait counter is 8+ bits, sized to TIMEOUT_CYC.
- Latency: start to resp_valid = 1 + SETTLE_CYC + sum over evaluations of (1 + wait_i + RELAX_CYC) + 1 cycles, where wait_i = WAIT cycles up to and including the ready cycle.
- start asserted in the same cycle as resp_valid is ignored (state is DONE); the controller must pulse again.

Optional Feature:
- Macro: PUF_STABILITY_EN.
- Defined:
  - Adds output port unstable (1 bit), registered in DONE.
  - unstable=1 when 0 < ones_cnt < NUM_EVAL (the PUF gave a mixed response); 0 otherwise, and 0 on timeout.
  - Reset value 0; holds like resp_bit.
- Undefined: port absent; no extra logic.

Test Plan:
- Reset hold: rst=1 for 3 cycles mid-WAIT -> all outputs 0, state IDLE, no resp_valid pulse.
- Nominal run: NUM_EVAL=15, ready returned 2 cycles after trig rise, puf_resp=1 on 10 of 15 evaluations -> ones_cnt=10, resp_bit=1, timeout_err=0, resp_valid one cycle, start-to-valid latency matches the formula (= 1+4+15×(1+2+4)+1 = 111).
- Minority: puf_resp=1 on 7 of 15 -> resp_bit=0, ones_cnt=7; with PUF_STABILITY_EN, unstable=1. All 15 ones -> unstable=0.
- Timeout: TIMEOUT_CYC=8, puf_resp_ready never asserted -> puf_trig low after 8 WAIT cycles, timeout_err=1, resp_bit=0, resp_valid pulses once.
- Protocol abuse:
  - start pulsed during RELAX -> ignored; puf_chal unchanged.
  - puf_resp_ready pulsed during RELAX -> ones_cnt unchanged.
  - Ready and timeout in the same cycle -> sample counted, no error.
- Back-to-back: second start the cycle after resp_valid with a new chal_in (0xA5A5_5A5A_0F0F_F0F0) -> puf_chal updates, counters clear, second run completes independently.
